mmm_shiftreg_mw: RTL and testbench
==================================

Name: mmm_shiftreg_mw

Overview:
- Multi-word operand/result register for the Montgomery multiplier (MMM) datapath.
- Generalises the single-word R register to NWORDS words of WIDTH bits.
- Keeps the legacy parallel load (lock/ld_r select between reg_rji and A).
- Adds word-serial shift-in and non-destructive word-serial read-out, both with valid/ready handshakes, so the RSA top can stream operands through a narrow bus.

Parameters:
- WIDTH, 8, bits per word.
- NWORDS, 4, words held. Must be >= 2. Total register width is W = WIDTH*NWORDS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstb  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous soft clear (successor of rst_mmm_i); active high.
- en  in  1  enable for the parallel load path only.
- lock  in  1  selects reg_rji when high, together with ld_r.
- ld_r  in  1  parallel load request.
- reg_rji  in  W  parallel source, used when lock=1.
- A  in  W  parallel source, used when lock=0.
- in_start  in  1  pulse: begin serial shift-in of NWORDS words.
- wr_valid  in  1  serial input word valid.
- wr_word  in  WIDTH  serial input word.
- wr_ready  out  1  serial input accept.
- rd_start  in  1  pulse: begin serial read-out.
- rd_valid  out  1  serial output word valid.
- rd_word  out  WIDTH  serial output word; always equals R_i[WIDTH-1:0].
- rd_ready  in  1  serial output accept.
- rd_last  out  1  marks the final word of the read-out.
- busy  out  1  high whenever the FSM is not in IDLE.
- op_done  out  1  one-cycle pulse when a serial operation completes.
- R_i  out  W  register contents.

Behaviour:
- Reset (rstb=0, asynchronous):
  - R_i=0, word counter=0, state=IDLE.
  - wr_ready, rd_valid, rd_last, busy and op_done all 0.
- clr=1 has the highest synchronous priority and produces the same state as reset on the next edge, including mid-operation. A partially shifted value is discarded and no op_done is generated.
- FSM states: IDLE, SHIFT_IN, SHIFT_OUT. busy = (state != IDLE).
- IDLE, parallel load (only when en=1 and ld_r=1):
  - lock=1 -> R_i <= reg_rji.
  - lock=0 -> R_i <= A.
  - ld_r=0 or en=0 -> hold.
  - ld_r is ignored in SHIFT_IN and SHIFT_OUT.
- IDLE, start requests:
  - in_start=1 -> SHIFT_IN, counter<=0.
  - Otherwise rd_start=1 -> SHIFT_OUT, counter<=0.
  - in_start wins if both are asserted. If a start and a parallel load coincide, the parallel load still takes effect on that edge, and the FSM enters the new state on the same edge.
- SHIFT_IN:
  - wr_ready=1 throughout.
  - On each wr_valid&wr_ready: R_i <= {wr_word, R_i[W-1:WIDTH]}, i.e. words enter at the MS end and shift toward the LS end; counter increments.
  - The NWORDS-th accepted word returns the FSM to IDLE and sets op_done=1 for the next cycle. The first word sent ends up in word 0.
  - wr_valid=0 stalls with no change.
- SHIFT_OUT:
  - rd_valid=1 throughout; rd_word=R_i[WIDTH-1:0].
  - rd_last=1 when counter==NWORDS-1.
  - On each rd_valid&rd_ready: R_i <= {R_i[WIDTH-1:0], R_i[W-1:WIDTH]} (rotate right by one word); counter increments.
  - After the last transfer: FSM returns to IDLE, op_done pulses for one cycle, and R_i equals its pre-read value (non-destructive).
  - rd_ready=0 holds rd_valid, rd_word and rd_last stable.
- Start pulses received while busy are ignored.
- Counter: $clog2(NWORDS) bits. It never exceeds NWORDS-1 and is cleared on entry to either serial state.
- Latency:
  - Parallel load appears on R_i one cycle after the sampling edge.
  - A full serial operation takes a minimum of NWORDS handshake cycles plus 1 cycle for the start.

Decomposition:
- Shared package mmm_pkg holds:
  - the state enum (IDLE, SHIFT_IN, SHIFT_OUT);
  - a localparam function for the counter width ($clog2 with a minimum of 1).
- One sub-module, mmm_word_ctr: a parameterised up-counter with clear, increment and a terminal-count flag (counter==NWORDS-1). It is reused by the other MMM serial ports.

Test Plan (WIDTH=8, NWORDS=4):
- Reset and clear: drive rstb=0 mid-SHIFT_IN, then release; separately assert clr in the middle of SHIFT_OUT -> R_i=0, busy=0, rd_valid=0 and no op_done in both cases.
- Parallel load: en=1, ld_r=1, lock=1, reg_rji=32'hDEADBEEF -> R_i=32'hDEADBEEF next cycle. Then lock=0, A=32'h12345678 -> R_i=32'h12345678. With en=0 -> R_i holds.
- Shift-in: in_start, then words 11,22,33,44 with wr_valid gaps inserted -> R_i=32'h44332211, op_done pulses exactly once, and ld_r asserted during the transfer is ignored.
- Read-out with backpressure: R_i=32'hA1B2C3D4, rd_start, rd_ready toggling -> rd_word sequence D4,C3,B2,A1 with rd_last only on A1; words stay stable while stalled; R_i=32'hA1B2C3D4 afterwards.
- Simultaneous events: in_start and rd_start in the same cycle -> SHIFT_IN is entered. rd_start while busy -> ignored, and no second op_done.

Source files
------------

// File: rtl/mmm_shiftreg_mw_pkg.sv
// rtl/mmm_shiftreg_mw_pkg.sv - shared state type and sizing helper for the MMM serial ports
package mmm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_IN  = 2'd1,
        SHIFT_OUT = 2'd2
    } mmm_state_e;

    // Counter width for a word index 0..n-1; never narrower than one bit
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mmm_shiftreg_mw_if.sv
// rtl/mmm_shiftreg_mw_if.sv - control, parallel-load and word-serial bus of the MMM multi-word register
interface mmm_shiftreg_mw_if #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
);
    localparam int W = WIDTH * NWORDS;

    logic             clr;
    logic             en;
    logic             lock;
    logic             ld_r;
    logic [W-1:0]     reg_rji;
    logic [W-1:0]     A;
    logic             in_start;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_word;
    logic             wr_ready;
    logic             rd_start;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_word;
    logic             rd_ready;
    logic             rd_last;
    logic             busy;
    logic             op_done;
    logic [W-1:0]     R_i;

    modport master (
        output clr, en, lock, ld_r, reg_rji, A,
        output in_start, wr_valid, wr_word, rd_start, rd_ready,
        input  wr_ready, rd_valid, rd_word, rd_last, busy, op_done, R_i
    );

    modport slave (
        input  clr, en, lock, ld_r, reg_rji, A,
        input  in_start, wr_valid, wr_word, rd_start, rd_ready,
        output wr_ready, rd_valid, rd_word, rd_last, busy, op_done, R_i
    );

endinterface

// File: rtl/mmm_word_ctr.sv
// rtl/mmm_word_ctr.sv - word index counter with clear, increment and terminal-count flag
module mmm_word_ctr
    import mmm_pkg::*;
#(
    parameter int  NWORDS = 4,
    localparam int CW     = ctr_width(NWORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = (cnt_q == CW'(NWORDS - 1));
    assign cnt_o = cnt_q;

    // Wrapping at terminal count keeps the index inside 0..NWORDS-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmm_shiftreg_mw.sv
// rtl/mmm_shiftreg_mw.sv - MMM multi-word R register with parallel load and word-serial shift-in/read-out
module mmm_shiftreg_mw
    import mmm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic              clk,
    input  logic              rstb,
    mmm_shiftreg_mw_if.slave  bus
);

    localparam int W  = WIDTH * NWORDS;
    localparam int CW = ctr_width(NWORDS);

    mmm_state_e    state_q;
    logic [W-1:0]  r_q;
    logic          op_done_q;

    logic          wr_fire;
    logic          rd_fire;
    logic          start;
    logic          tc;
    logic          last_xfer;
    logic [CW-1:0] cnt;

    assign wr_fire   = (state_q == SHIFT_IN)  && bus.wr_valid;
    assign rd_fire   = (state_q == SHIFT_OUT) && bus.rd_ready;
    assign start     = (state_q == IDLE) && (bus.in_start || bus.rd_start);
    assign last_xfer = (cnt == CW'(NWORDS - 1));

    mmm_word_ctr #(
        .NWORDS (NWORDS)
    ) u_word_ctr (
        .clk   (clk),
        .rst_n (rstb),
        .clr_i (bus.clr || start),
        .inc_i (wr_fire || rd_fire),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            r_q       <= '0;
            op_done_q <= 1'b0;
        end else if (bus.clr) begin
            state_q   <= IDLE;
            r_q       <= '0;
            op_done_q <= 1'b0;
        end else begin
            op_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A load coinciding with a start still lands before the serial op begins
                    if (bus.en && bus.ld_r) begin
                        r_q <= bus.lock ? bus.reg_rji : bus.A;
                    end
                    if (bus.in_start) begin
                        state_q <= SHIFT_IN;
                    end else if (bus.rd_start) begin
                        state_q <= SHIFT_OUT;
                    end
                end
                SHIFT_IN: begin
                    if (wr_fire) begin
                        r_q <= {bus.wr_word, r_q[W-1:WIDTH]};
                        if (last_xfer) begin
                            state_q   <= IDLE;
                            op_done_q <= 1'b1;
                        end
                    end
                end
                SHIFT_OUT: begin
                    // Rotation, not shift: after NWORDS transfers the value is back in place
                    if (rd_fire) begin
                        r_q <= {r_q[WIDTH-1:0], r_q[W-1:WIDTH]};
                        if (last_xfer) begin
                            state_q   <= IDLE;
                            op_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready = (state_q == SHIFT_IN);
    assign bus.rd_valid = (state_q == SHIFT_OUT);
    assign bus.rd_last  = (state_q == SHIFT_OUT) && tc;
    assign bus.busy     = (state_q != IDLE);
    assign bus.op_done  = op_done_q;
    assign bus.rd_word  = r_q[WIDTH-1:0];
    assign bus.R_i      = r_q;

endmodule

// File: tb/tb_mmm_shiftreg_mw.sv
// tb/tb_mmm_shiftreg_mw.sv - self-checking bench for mmm_shiftreg_mw
module tb_mmm_shiftreg_mw;

    localparam int WIDTH  = 8;
    localparam int NWORDS = 4;
    localparam int W      = WIDTH * NWORDS;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    mmm_shiftreg_mw_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus();

    mmm_shiftreg_mw #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] word_of(input logic [W-1:0] v, input int i);
        logic [W-1:0] s;
        s = v >> (WIDTH * i);
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [W-1:0] pack_words(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                                                input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
        return W'(w0) + (W'(w1) << WIDTH) + (W'(w2) << (2 * WIDTH)) + (W'(w3) << (3 * WIDTH));
    endfunction

    task automatic set_idle();
        bus.clr = 0; bus.en = 0; bus.lock = 0; bus.ld_r = 0;
        bus.in_start = 0; bus.wr_valid = 0; bus.wr_word = '0;
        bus.rd_start = 0; bus.rd_ready = 0;
    endtask

    task automatic load_a(input logic [W-1:0] v);
        bus.en = 1; bus.ld_r = 1; bus.lock = 0; bus.A = v;
        @(negedge clk);
        bus.en = 0; bus.ld_r = 0;
    endtask

    task automatic test_reset();
        logic [4:0] fl;
        int dn;
        set_idle(); bus.reg_rji = '0; bus.A = '0;
        rstb = 0;
        repeat (2) @(negedge clk);
        fl = {bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.op_done};
        n_total++; if (bus.R_i !== '0) $display("FAIL reset_R got %h exp 0", bus.R_i); else n_pass++;
        n_total++; if (fl !== 5'b0) $display("FAIL reset_flags got %b exp 00000", fl); else n_pass++;
        rstb = 1;
        @(negedge clk);
        load_a(32'h5A5A5A5A);
        bus.in_start = 1;
        @(negedge clk);
        bus.in_start = 0;
        bus.wr_valid = 1; bus.wr_word = 8'h77;
        repeat (2) @(negedge clk);
        rstb = 0;
        #1;
        fl = {bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.op_done};
        n_total++; if (bus.R_i !== '0) $display("FAIL async_rst_R got %h exp 0", bus.R_i); else n_pass++;
        n_total++; if (fl !== 5'b0) $display("FAIL async_rst_flags got %b exp 00000", fl); else n_pass++;
        @(negedge clk);
        set_idle();
        rstb = 1;
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.op_done) dn++;
        end
        n_total++; if (dn !== 0) $display("FAIL rst_no_done got %0d exp 0", dn); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_idle_busy got %b exp 0", bus.busy); else n_pass++;
    endtask

    task automatic test_parallel();
        logic [W-1:0] exp;
        logic e, l, lk;
        logic [W-1:0] a, rj;
        bus.en = 1; bus.ld_r = 1; bus.lock = 1; bus.reg_rji = 32'hDEADBEEF; bus.A = 32'h0BADF00D;
        @(negedge clk);
        n_total++; if (bus.R_i !== 32'hDEADBEEF) $display("FAIL load_rji got %h exp deadbeef", bus.R_i); else n_pass++;
        bus.lock = 0; bus.A = 32'h12345678;
        @(negedge clk);
        n_total++; if (bus.R_i !== 32'h12345678) $display("FAIL load_A got %h exp 12345678", bus.R_i); else n_pass++;
        bus.en = 0; bus.lock = 1; bus.A = 32'hCAFEF00D;
        @(negedge clk);
        n_total++; if (bus.R_i !== 32'h12345678) $display("FAIL hold_en0 got %h exp 12345678", bus.R_i); else n_pass++;
        exp = 32'h12345678;
        for (int k = 0; k < 8; k++) begin
            e = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1)); lk = 1'($urandom_range(0, 1));
            a = $urandom; rj = $urandom;
            bus.en = e; bus.ld_r = l; bus.lock = lk; bus.A = a; bus.reg_rji = rj;
            if (e && l) exp = lk ? rj : a;
            @(negedge clk);
            n_total++; if (bus.R_i !== exp) $display("FAIL rand_load%0d got %h exp %h", k, bus.R_i, exp); else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_shift_in(input logic [W-1:0] val, input bit gaps);
        int sent, dn, guard;
        bus.in_start = 1;
        @(negedge clk);
        bus.in_start = 0;
        n_total++; if (bus.wr_ready !== 1'b1) $display("FAIL sin_ready got %b exp 1", bus.wr_ready); else n_pass++;
        bus.en = 1; bus.ld_r = 1; bus.lock = 0; bus.A = ~val;
        sent = 0; dn = 0; guard = 0;
        while (sent < NWORDS && guard < 200) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.wr_valid = 0;
            end else begin
                bus.wr_valid = 1; bus.wr_word = word_of(val, sent); sent++;
            end
            @(negedge clk);
            if (bus.op_done) dn++;
        end
        n_total++; if (sent !== NWORDS) $display("FAIL sin_timeout got %0d exp %0d", sent, NWORDS); else n_pass++;
        n_total++; if (bus.op_done !== 1'b1) $display("FAIL sin_done_pulse got %b exp 1", bus.op_done); else n_pass++;
        set_idle();
        repeat (3) begin
            @(negedge clk);
            if (bus.op_done) dn++;
        end
        n_total++; if (bus.R_i !== val) $display("FAIL sin_R got %h exp %h", bus.R_i, val); else n_pass++;
        n_total++; if (dn !== 1) $display("FAIL sin_done_count got %0d exp 1", dn); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL sin_busy got %b exp 0", bus.busy); else n_pass++;
    endtask

    task automatic test_read_out(input logic [W-1:0] val, input bit bp);
        int idx, dn, guard;
        logic rdy;
        load_a(val);
        bus.rd_start = 1;
        @(negedge clk);
        bus.rd_start = 0;
        idx = 0; dn = 0; guard = 0;
        while (idx < NWORDS && guard < 200) begin
            n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL rout_valid%0d got %b exp 1", idx, bus.rd_valid); else n_pass++;
            n_total++; if (bus.rd_word !== word_of(val, idx)) $display("FAIL rout_word%0d got %h exp %h", idx, bus.rd_word, word_of(val, idx)); else n_pass++;
            n_total++; if (bus.rd_last !== (idx == NWORDS - 1)) $display("FAIL rout_last%0d got %b exp %b", idx, bus.rd_last, (idx == NWORDS - 1)); else n_pass++;
            rdy = bp ? ((guard == 0) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
            guard++;
            bus.rd_ready = rdy;
            @(negedge clk);
            if (bus.op_done) dn++;
            if (rdy) idx++;
        end
        n_total++; if (idx !== NWORDS) $display("FAIL rout_timeout got %0d exp %0d", idx, NWORDS); else n_pass++;
        bus.rd_ready = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.op_done) dn++;
        end
        n_total++; if (bus.R_i !== val) $display("FAIL rout_R got %h exp %h", bus.R_i, val); else n_pass++;
        n_total++; if (dn !== 1) $display("FAIL rout_done_count got %0d exp 1", dn); else n_pass++;
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL rout_valid_end got %b exp 0", bus.rd_valid); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] w[NWORDS];
        logic [W-1:0] a;
        int dn;
        for (int i = 0; i < NWORDS; i++) w[i] = WIDTH'($urandom);
        a = $urandom;
        bus.in_start = 1; bus.rd_start = 1; bus.en = 1; bus.ld_r = 1; bus.lock = 0; bus.A = a;
        @(negedge clk);
        set_idle();
        n_total++; if (bus.R_i !== a) $display("FAIL sim_load got %h exp %h", bus.R_i, a); else n_pass++;
        n_total++; if ({bus.wr_ready, bus.rd_valid} !== 2'b10) $display("FAIL sim_state got %b exp 10", {bus.wr_ready, bus.rd_valid}); else n_pass++;
        dn = 0;
        for (int i = 0; i < NWORDS; i++) begin
            bus.wr_valid = 1; bus.wr_word = w[i];
            bus.rd_start = (i == 1); bus.in_start = (i == 2);
            @(negedge clk);
            if (bus.op_done) dn++;
        end
        set_idle();
        repeat (4) begin
            @(negedge clk);
            if (bus.op_done) dn++;
        end
        n_total++; if (bus.R_i !== pack_words(w[0], w[1], w[2], w[3])) $display("FAIL sim_R got %h exp %h", bus.R_i, pack_words(w[0], w[1], w[2], w[3])); else n_pass++;
        n_total++; if (dn !== 1) $display("FAIL sim_done_count got %0d exp 1", dn); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL sim_busy got %b exp 0", bus.busy); else n_pass++;
    endtask

    task automatic test_clear();
        logic [4:0] fl;
        int dn;
        load_a(32'hA1B2C3D4);
        bus.rd_start = 1;
        @(negedge clk);
        bus.rd_start = 0; bus.rd_ready = 1;
        repeat (2) @(negedge clk);
        bus.clr = 1;
        @(negedge clk);
        bus.clr = 0;
        fl = {bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.op_done};
        n_total++; if (bus.R_i !== '0) $display("FAIL clr_R got %h exp 0", bus.R_i); else n_pass++;
        n_total++; if (fl !== 5'b0) $display("FAIL clr_flags got %b exp 00000", fl); else n_pass++;
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.op_done) dn++;
        end
        set_idle();
        n_total++; if (dn !== 0) $display("FAIL clr_no_done got %0d exp 0", dn); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        bus.reg_rji = '0; bus.A = '0;
        @(negedge clk);
        test_reset();
        test_parallel();
        test_shift_in(32'h44332211, 1'b1);
        test_shift_in($urandom, 1'b0);
        test_read_out(32'hA1B2C3D4, 1'b1);
        test_read_out($urandom, 1'b1);
        test_read_out($urandom, 1'b0);
        test_simultaneous();
        test_clear();
        test_read_out($urandom, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
